basic_selftest: RTL and testbench
=================================

# basic_selftest

Sequencer that exercises the two-input `basic` logic unit (`a_and_b`, `a_or_b`, `a_xor_b`) in hardware. It applies all four input combinations in a fixed order, holds each one for a programmable number of cycles, and samples the unit's outputs. It checks the samples against the expected truth table and reports pass/fail, a per-vector failure mask and the captured results. It sits beside the `basic` instance: it drives that instance's `a`/`b` inputs and reads its three outputs back.

## Interface
- `HOLD`, default 1: cycles each vector is driven before it is sampled; legal range ≥1; `HOLD`=0 is illegal.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request a test run; sampled only in IDLE.
- `a`  out  1  drives `a` of the unit under test.
- `b`  out  1  drives `b` of the unit under test.
- `a_and_b`  in  1  AND output from the unit.
- `a_or_b`  in  1  OR output from the unit.
- `a_xor_b`  in  1  XOR output from the unit.
- `busy`  out  1  high while vectors are being applied.
- `done`  out  1  single-cycle pulse at the end of a run.
- `pass`  out  1  1 if all 4 vectors matched; valid from the `done` cycle and held until the next accepted `start`.
- `err_count`  out  3  number of failing vectors, 0..4.
- `fail_vec`  out  4  bit i set when vector i = {a,b} mismatched.
- `captured`  out  12  sampled {and,or,xor} per vector; vector i occupies [3i+2:3i].

## Operation
- Vector order is 0,1,2,3, with {a,b} = vector index: 00, 01, 10, 11.
- Expected outputs per vector: and=a&b, or=a|b, xor=a^b.
- A vector mismatches if any of the 3 outputs differs. Comparison is case-inequality, so X/Z on an input counts as a mismatch.
- States:
  - IDLE: a=b=0, busy=0. `start`=1 → DRIVE with vec=0. This transition clears `err_count`, `fail_vec`, `captured` and `pass`.
  - DRIVE: a,b = vec; busy=1; hold counter counts `HOLD` cycles, then → SAMPLE.
  - SAMPLE: a,b still = vec; busy=1. At the end of the cycle:
    - register the 3 inputs into `captured[3vec+2:3vec]`;
    - on mismatch, set `fail_vec[vec]` and increment `err_count`.
    - If vec==3 → DONE; otherwise vec+1 and → DRIVE.
  - DONE: done=1 for one cycle; busy=0; a=b=0; `pass` = (`err_count`==0), using the updated count. Then → IDLE.
- `start` is ignored in DRIVE, SAMPLE and DONE; it is not queued.
- Results hold after DONE until the next accepted start or reset.
- Hold-counter width is clog2(HOLD+1); the counter reloads on every vector.

## Timing
- Reset values (one edge after `rst`=1): a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, captured=0; state=IDLE.
- Let edge 0 be the edge at which `start`=1 is sampled in IDLE:
  - cycles 1..4(HOLD+1): busy=1;
  - vector v is driven during cycles v(HOLD+1)+1 .. (v+1)(HOLD+1);
  - the last cycle of each window is SAMPLE.
- Cycle 4(HOLD+1)+1: done=1, busy=0, pass/err_count/fail_vec/captured valid.
- Earliest next accept is the following IDLE cycle. With `start` held high, the run period is 4(HOLD+1)+2 cycles.
- Reset mid-run: the next edge returns every output to its reset value; no `done` pulse is issued.
- Reset has priority over `start` on the same edge.
- The unit under test is combinational, and each vector is held ≥2 cycles before capture, so its outputs are settled when sampled.

## Test plan
- Correct `basic`, HOLD=1, one-cycle `start` pulse → busy high for cycles 1–8; a,b = 00,00,01,01,10,10,11,11; done=1 at cycle 9; pass=1, err_count=0, fail_vec=4'b0000, captured=12'hCD8.
- `a_xor_b` stuck at 0, HOLD=1 → done at cycle 9; pass=0, err_count=2, fail_vec=4'b0110, captured=12'hC90.
- Unit outputs left X → pass=0, err_count=4, fail_vec=4'hF.
- HOLD=3 → busy for 16 cycles; a/b change every 4 cycles; done at cycle 17.
- Extra `start` pulses at cycles 3 and 9 (the DONE cycle) are ignored, with one done per accepted start. `start` held high continuously → done pulses at cycles 9, 19, 29.
- `rst`=1 at cycle 4 of a run → cycle 5 shows a=b=0, busy=0, captured=0, fail_vec=0; no done. A new start afterwards completes normally with pass=1.

Source files
------------

// File: rtl/basic_selftest.sv
// Hardware self-test sequencer for the two-input basic logic unit.
// Walks {a,b} through 00..11, samples and/or/xor, and reports the results.
module basic_selftest #(
  parameter int HOLD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        a,
  output logic        b,
  input  logic        a_and_b,
  input  logic        a_or_b,
  input  logic        a_xor_b,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [2:0]  err_count,
  output logic [3:0]  fail_vec,
  output logic [11:0] captured
);

  localparam int CW = $clog2(HOLD + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);

  logic [1:0]    state;
  logic [1:0]    vec;
  logic [CW-1:0] cnt;
  logic [2:0]    obs;
  logic [2:0]    exp_v;
  logic          miss;

  assign obs   = {a_and_b, a_or_b, a_xor_b};
  assign exp_v = {vec[1] & vec[0], vec[1] | vec[0], vec[1] ^ vec[0]};
  // X/Z on the unit outputs must count as a failure
  assign miss  = (obs !== exp_v);

  assign busy = (state == DRIVE) || (state == SAMPLE);
  assign done = (state == DONE);
  assign a    = busy & vec[1];
  assign b    = busy & vec[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vec       <= '0;
      cnt       <= '0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
      captured  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= DRIVE;
            vec       <= '0;
            cnt       <= '0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
            captured  <= '0;
          end
        end
        DRIVE: begin
          if (cnt == HOLD_LAST) state <= SAMPLE;
          else cnt <= cnt + 1'b1;
        end
        SAMPLE: begin
          captured[int'(vec) * 3 +: 3] <= obs;
          if (miss) begin
            fail_vec[vec] <= 1'b1;
            err_count     <= err_count + 3'd1;
          end
          if (vec == 2'd3) begin
            state <= DONE;
            // pass reflects the count including this last vector
            pass  <= (err_count == 3'd0) && !miss;
          end else begin
            vec   <= vec + 2'd1;
            cnt   <= '0;
            state <= DRIVE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_basic_selftest.sv
// Self-checking bench for basic_selftest with a behavioural basic unit.
// Expected results are queued at start and compared when done pulses.
module tb_basic_selftest;

  typedef struct packed {
    logic        pass;
    logic [2:0]  err;
    logic [3:0]  fv;
    logic [11:0] cap;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, start1, a1, b1, and1, or1, xor1;
  logic        busy1, done1, pass1;
  logic [2:0]  err1;
  logic [3:0]  fv1;
  logic [11:0] cap1;
  logic [1:0]  mode1;

  logic        rst3, start3, a3, b3, and3, or3, xor3;
  logic        busy3, done3, pass3;
  logic [2:0]  err3;
  logic [3:0]  fv3;
  logic [11:0] cap3;

  int checks = 0;
  int errors = 0;

  res_t q1[$];
  res_t q3[$];

  // mode 0: correct, 1: xor stuck at 0, 2: outputs undriven (X)
  assign and1 = (mode1 == 2'd2) ? 1'bx : (a1 & b1);
  assign or1  = (mode1 == 2'd2) ? 1'bx : (a1 | b1);
  assign xor1 = (mode1 == 2'd2) ? 1'bx :
                (mode1 == 2'd1) ? 1'b0 : (a1 ^ b1);

  assign and3 = a3 & b3;
  assign or3  = a3 | b3;
  assign xor3 = a3 ^ b3;

  basic_selftest #(.HOLD(1)) u1 (
    .clk(clk), .rst(rst1), .start(start1),
    .a(a1), .b(b1),
    .a_and_b(and1), .a_or_b(or1), .a_xor_b(xor1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fv1), .captured(cap1)
  );

  basic_selftest #(.HOLD(3)) u3 (
    .clk(clk), .rst(rst3), .start(start3),
    .a(a3), .b(b3),
    .a_and_b(and3), .a_or_b(or3), .a_xor_b(xor3),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .fail_vec(fv3), .captured(cap3)
  );

  function automatic res_t model(input logic [1:0] m);
    res_t r;
    logic [2:0] ideal, got;
    logic ia, ib;
    r = '0;
    for (int v = 0; v < 4; v++) begin
      ia = v[1];
      ib = v[0];
      ideal = {ia & ib, ia | ib, ia ^ ib};
      case (m)
        2'd1:    got = {ideal[2:1], 1'b0};
        2'd2:    got = 3'bxxx;
        default: got = ideal;
      endcase
      r.cap[v*3 +: 3] = got;
      if (got !== ideal) begin
        r.fv[v] = 1'b1;
        r.err   = r.err + 3'd1;
      end
    end
    r.pass = (r.err == 3'd0);
    return r;
  endfunction

  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      res_t e;
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL u1_unexpected_done at %0t", $time);
      end else begin
        e = q1.pop_front();
        if ({pass1, err1, fv1, cap1} !== e) begin
          errors++;
          $display("FAIL u1_result got pass=%b err=%0d fv=%b cap=%h want pass=%b err=%0d fv=%b cap=%h",
                   pass1, err1, fv1, cap1, e.pass, e.err, e.fv, e.cap);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done3 === 1'b1) begin
      res_t e;
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL u3_unexpected_done at %0t", $time);
      end else begin
        e = q3.pop_front();
        if ({pass3, err3, fv3, cap3} !== e) begin
          errors++;
          $display("FAIL u3_result got pass=%b err=%0d fv=%b cap=%h want pass=%b err=%0d fv=%b cap=%h",
                   pass3, err3, fv3, cap3, e.pass, e.err, e.fv, e.cap);
        end
      end
    end
  end

  task automatic test_reset();
    rst1 = 1'b1; rst3 = 1'b1;
    start1 = 1'b0; start3 = 1'b0;
    mode1 = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a1, b1, busy1, done1, pass1, err1, fv1, cap1} !== 24'd0) begin
      errors++;
      $display("FAIL reset_u1 got %h want 0",
               {a1, b1, busy1, done1, pass1, err1, fv1, cap1});
    end
    checks++;
    if ({a3, b3, busy3, done3, pass3, err3, fv3, cap3} !== 24'd0) begin
      errors++;
      $display("FAIL reset_u3 got %h want 0",
               {a3, b3, busy3, done3, pass3, err3, fv3, cap3});
    end
    rst1 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic(input logic [1:0] m, input logic [11:0] want_cap);
    res_t e;
    e = model(m);
    mode1 = m;
    @(negedge clk);
    start1 = 1'b1;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      logic [1:0] v;
      v = 2'((c - 1) / 2);
      checks++;
      if (c <= 8) begin
        if ({busy1, done1, a1, b1} !== {2'b10, v}) begin
          errors++;
          $display("FAIL run_m%0d_c%0d busy/done/a/b got %b want %b",
                   m, c, {busy1, done1, a1, b1}, {2'b10, v});
        end
      end else if (c == 9) begin
        if ({busy1, done1, a1, b1} !== 4'b0100) begin
          errors++;
          $display("FAIL done_m%0d busy/done/a/b got %b want 0100",
                   m, {busy1, done1, a1, b1});
        end
      end else begin
        if ({busy1, done1, pass1, err1, fv1, cap1} !== {2'b00, e}) begin
          errors++;
          $display("FAIL hold_m%0d got %b want %b",
                   m, {busy1, done1, pass1, err1, fv1, cap1}, {2'b00, e});
        end
        checks++;
        if (cap1 !== want_cap) begin
          errors++;
          $display("FAIL cap_m%0d got %h want %h", m, cap1, want_cap);
        end
      end
      if (c == 1) begin
        checks++;
        if ({pass1, err1, fv1, cap1} !== 20'd0) begin
          errors++;
          $display("FAIL clear_m%0d got %h want 0", m, {pass1, err1, fv1, cap1});
        end
      end
      if (c < 10) @(negedge clk);
    end
  endtask

  task automatic test_hold3();
    @(negedge clk);
    start3 = 1'b1;
    q3.push_back(model(2'd0));
    @(negedge clk);
    start3 = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      logic [1:0] v;
      logic [3:0] want;
      v = 2'((c - 1) / 4);
      want = (c <= 16) ? {2'b10, v} : (c == 17) ? 4'b0100 : 4'b0000;
      checks++;
      if ({busy3, done3, a3, b3} !== want) begin
        errors++;
        $display("FAIL hold3_c%0d busy/done/a/b got %b want %b",
                 c, {busy3, done3, a3, b3}, want);
      end
      if (c < 18) @(negedge clk);
    end
  endtask

  task automatic test_start_ignored();
    mode1 = 2'd0;
    @(negedge clk);
    start1 = 1'b1;
    q1.push_back(model(2'd0));
    @(negedge clk);
    for (int c = 1; c <= 20; c++) begin
      checks++;
      if (done1 !== (c == 9)) begin
        errors++;
        $display("FAIL ignore_c%0d done got %b want %b", c, done1, (c == 9));
      end
      start1 = (c == 3) || (c == 9);
      @(negedge clk);
    end
    start1 = 1'b0;
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL ignore_pending got %0d want 0", q1.size());
    end
  endtask

  task automatic test_start_held();
    mode1 = 2'd0;
    @(negedge clk);
    start1 = 1'b1;
    repeat (3) q1.push_back(model(2'd0));
    @(negedge clk);
    for (int c = 1; c <= 32; c++) begin
      checks++;
      if (done1 !== (c == 9 || c == 19 || c == 29)) begin
        errors++;
        $display("FAIL held_c%0d done got %b", c, done1);
      end
      if (c == 29) start1 = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL held_pending got %0d want 0", q1.size());
    end
  endtask

  task automatic test_reset_midrun();
    mode1 = 2'd0;
    @(negedge clk);
    start1 = 1'b1;
    q1.push_back(model(2'd0));
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    rst1 = 1'b1;
    q1.delete();
    @(negedge clk);
    checks++;
    if ({a1, b1, busy1, done1, pass1, err1, fv1, cap1} !== 24'd0) begin
      errors++;
      $display("FAIL midrun_reset got %h want 0",
               {a1, b1, busy1, done1, pass1, err1, fv1, cap1});
    end
    rst1 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      checks++;
      if ({busy1, done1} !== 2'b00) begin
        errors++;
        $display("FAIL midrun_quiet_c%0d busy/done got %b want 00", c, {busy1, done1});
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic(2'd0, 12'hCD8);
    test_basic(2'd1, 12'hC90);
    test_basic(2'd2, 12'hxxx);
    test_basic(2'd0, 12'hCD8);
    test_hold3();
    test_start_ignored();
    test_start_held();
    test_reset_midrun();
    test_basic(2'd0, 12'hCD8);
    repeat (3) @(negedge clk);
    checks++;
    if (q1.size() + q3.size() != 0) begin
      errors++;
      $display("FAIL final_pending got %0d want 0", q1.size() + q3.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
